// File: rtl/spi_bist_pkg.sv
// Shared types for the SPI memory BIST: sequencer states, failure-kind encodings
// and the address-keyed data pattern written and later expected back.
package spi_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_GAP,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_FINISH
    } bist_state_t;

    typedef enum logic [1:0] {
        FK_NONE     = 2'b00,
        FK_MISMATCH = 2'b01,
        FK_ERROR    = 2'b10,
        FK_TIMEOUT  = 2'b11
    } fail_kind_t;

    function automatic logic [7:0] pattern(input logic [7:0] addr, input logic [7:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/spi_mem_bist.sv
// Write-then-read-compare self-test sweep over an address range of the SPI memory
// path, acting as the requester on the subsystem's host command interface.
module spi_mem_bist
    import spi_bist_pkg::*;
#(
    parameter logic [7:0] ADDR_FIRST = 8'h00,
    parameter logic [7:0] ADDR_LAST  = 8'h1F,
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       wr,
    output logic [7:0] addr,
    output logic [7:0] data_in,
    input  logic [7:0] data_out,
    input  logic       done,
    input  logic       error,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [7:0] fail_addr,
    output logic [7:0] fail_exp,
    output logic [7:0] fail_got,
    output logic [1:0] fail_kind
);

    localparam int TW = $clog2(TIMEOUT + 1);

    bist_state_t state;
    logic        rd_phase;
    logic [TW-1:0] tmo_cnt;
    fail_kind_t  hit_kind;
    logic [7:0]  hit_got;

    // The addr output doubles as the sweep counter, so it only moves when a new command is issued.
    always_comb begin
        hit_kind = FK_NONE;
        hit_got  = 8'h00;
        if (state == ST_WR_WAIT || state == ST_RD_WAIT) begin
            if (done) begin
                if (error) begin
                    hit_kind = FK_ERROR;
                    hit_got  = data_out;
                end else if (state == ST_RD_WAIT && data_out != pattern(addr, SEED)) begin
                    hit_kind = FK_MISMATCH;
                    hit_got  = data_out;
                end
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                hit_kind = FK_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rd_phase  <= 1'b0;
            tmo_cnt   <= '0;
            wr        <= 1'b0;
            addr      <= 8'h00;
            data_in   <= 8'h00;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= 8'h00;
            fail_exp  <= 8'h00;
            fail_got  <= 8'h00;
            fail_kind <= FK_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= 8'h00;
                        fail_exp  <= 8'h00;
                        fail_got  <= 8'h00;
                        fail_kind <= FK_NONE;
                        tmo_cnt   <= '0;
                        busy      <= 1'b1;
                        rd_phase  <= 1'b0;
                        wr        <= 1'b1;
                        addr      <= ADDR_FIRST;
                        data_in   <= pattern(ADDR_FIRST, SEED);
                        state     <= ST_WR_ISSUE;
                    end
                end
                ST_WR_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= ST_WR_WAIT;
                end
                ST_RD_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= ST_RD_WAIT;
                end
                ST_WR_WAIT, ST_RD_WAIT: begin
                    // Only the first failure of a run is captured; the sweep keeps going.
                    if (hit_kind != FK_NONE && !fail) begin
                        fail      <= 1'b1;
                        fail_addr <= addr;
                        fail_exp  <= pattern(addr, SEED);
                        fail_got  <= hit_got;
                        fail_kind <= hit_kind;
                    end
                    if (done || hit_kind == FK_TIMEOUT) begin
                        state <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (addr != ADDR_LAST) begin
                        addr    <= addr + 8'd1;
                        data_in <= rd_phase ? 8'h00 : pattern(addr + 8'd1, SEED);
                        state   <= rd_phase ? ST_RD_ISSUE : ST_WR_ISSUE;
                    end else if (!rd_phase) begin
                        rd_phase <= 1'b1;
                        wr       <= 1'b0;
                        addr     <= ADDR_FIRST;
                        data_in  <= 8'h00;
                        state    <= ST_RD_ISSUE;
                    end else begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    pass  <= !fail;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
